// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter that occupies one 1 KiB MMIO slot.
// Software pushes bytes into a TX FIFO through TXDATA. A bit-timing state
// machine pops them one at a time and shifts them out LSB first on tx.
// The frame is one start bit (0), eight data bits and one stop bit (1).
//
// Register map (offset = data_address[9:0]):
//   0x000 TXDATA   W    push data_store[7:0]. Reads return 0.
//   0x004 STATUS   R/W1C
//                       bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky).
//                       [15:8] FIFO count. Writing 1 to bit3 clears overflow.
//   0x008 BAUD_DIV RW   [15:0] clk cycles per bit. A value of 0 behaves as 1.
//   0x00C CTRL     RW   bit0 tx_en, bit1 irq_en (only with UART_TX_IRQ_EN).
//   Any other offset reads 0 and ignores writes.
//
// Optional feature macro: UART_TX_IRQ_EN
//   defined   : irq is a registered level. It is high while irq_en is set,
//               the FIFO is empty and the FSM is idle.
//   undefined : irq is tied low, and CTRL bit1 is neither stored nor read back.
//
// Parameters:
//   FIFO_DEPTH  TX FIFO entries. Must be a power of two from 2 to 64.
//   DEFAULT_DIV reset value of BAUD_DIV.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   data_address  core data address. Only bits [9:0] are decoded.
//   data_store    core store data
//   data_read     1 = load, 0 = store
//   data_enable   data access valid
//   mmio_sel      slot select from the MMIO address decoder
//   data_fetch    registered read data. It is valid in the cycle after the access.
//   tx            serial output. It is high when idle.
//   irq           TX-done interrupt
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_address,
    input  logic [31:0] data_store,
    input  logic        data_read,
    input  logic        data_enable,
    input  logic        mmio_sel,
    output logic [31:0] data_fetch,
    output logic        tx,
    output logic        irq
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

    localparam logic [9:0] OFF_TXDATA = 10'h000;
    localparam logic [9:0] OFF_STATUS = 10'h004;
    localparam logic [9:0] OFF_BAUD   = 10'h008;
    localparam logic [9:0] OFF_CTRL   = 10'h00C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;
    logic [15:0] r_baud_div;
    logic        r_tx_en;

    state_t      r_state;
    logic [7:0]  r_shift;
    logic [15:0] r_div_lat;
    logic [15:0] r_cyc_cnt;
    logic [2:0]  r_bit_cnt;
    logic        r_tx;
    logic [31:0] r_data_fetch;

    // -------------------------------------------------------------------------
    // Access decode
    // -------------------------------------------------------------------------
    logic        w_wr;
    logic        w_rd;
    logic [9:0]  w_off;
    logic [AW:0] w_count;
    logic [7:0]  w_count_ext;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push_ok;
    logic        w_w1c_ovf;
    logic [15:0] w_div_eff;
    logic        w_bit_end;
    logic        w_irq_en_rd;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_wr  = mmio_sel & data_enable & ~data_read;
    assign w_rd  = mmio_sel & data_enable &  data_read;
    assign w_off = data_address[9:0];

    // The upper address bits are outside the slot, and the upper store bits
    // are not mapped to any register.
    assign w_unused = ^{data_address[31:10], data_store[31:16]};

    // The pointers carry one extra wrap bit, so full and empty can be told
    // apart without a separate counter.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_count_ext = 8'(w_count);
    assign w_full      = (w_count == C_DEPTH);
    assign w_empty     = (w_count == '0);
    assign w_busy      = (r_state != ST_IDLE);

    assign w_pop      = (r_state == ST_IDLE) & r_tx_en & ~w_empty;
    assign w_push_req = w_wr & (w_off == OFF_TXDATA);
    // A push while full is still accepted when a pop frees a slot in the same cycle.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_w1c_ovf  = w_wr & (w_off == OFF_STATUS) & data_store[3];

    assign w_div_eff = (r_baud_div == 16'd0) ? 16'd1 : r_baud_div;
    assign w_bit_end = (r_cyc_cnt == (r_div_lat - 16'd1));

    // -------------------------------------------------------------------------
    // FIFO storage. There is no reset here, because the pointers alone define
    // which entries are valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_store[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A dropped push and a W1C clear come from different offsets,
            // so they can never occur in the same cycle.
            if (w_push_req & ~w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (w_w1c_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Configuration registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_div <= DEFAULT_DIV;
            r_tx_en    <= 1'b0;
        end else if (w_wr) begin
            if (w_off == OFF_BAUD) begin
                r_baud_div <= data_store[15:0];
            end
            if (w_off == OFF_CTRL) begin
                r_tx_en <= data_store[0];
            end
        end
    end

`ifdef UART_TX_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_en <= 1'b0;
        end else if (w_wr && (w_off == OFF_CTRL)) begin
            r_irq_en <= data_store[1];
        end
    end

    // The interrupt is a level. It stays high while the transmitter has
    // nothing left to send, and it drops once a new byte is queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq_en & w_empty & (r_state == ST_IDLE) & ~w_pop;
        end
    end

    assign w_irq_en_rd = r_irq_en;
    assign irq         = r_irq;
`else
    assign w_irq_en_rd = 1'b0;
    assign irq         = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read path. STATUS reflects the state before this cycle's push or pop.
    // -------------------------------------------------------------------------
    always_comb begin
        w_rdata = 32'd0;
        case (w_off)
            OFF_STATUS: w_rdata = {16'd0, w_count_ext, 4'd0,
                                   r_overflow, w_busy, w_empty, w_full};
            OFF_BAUD:   w_rdata = {16'd0, r_baud_div};
            OFF_CTRL:   w_rdata = {30'd0, w_irq_en_rd, r_tx_en};
            default:    w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_fetch <= 32'd0;
        end else begin
            r_data_fetch <= w_rd ? w_rdata : 32'd0;
        end
    end

    // -------------------------------------------------------------------------
    // TX state machine. tx is registered and is updated on the same edge as
    // the state change, so each bit level lasts exactly div_lat cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_shift   <= 8'd0;
            r_div_lat <= 16'd1;
            r_cyc_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        // The divider is latched here, so a later BAUD_DIV
                        // write only affects the next frame.
                        r_shift   <= r_mem[r_rd_ptr[AW-1:0]];
                        r_div_lat <= w_div_eff;
                        r_cyc_cnt <= 16'd0;
                        r_tx      <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= 16'd0;
                        r_bit_cnt <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= 16'd0;
                        if (r_bit_cnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cyc_cnt <= 16'd0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign data_fetch = r_data_fetch;
    assign tx         = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_TXDATA = 32'h000;
    localparam logic [31:0] A_STATUS = 32'h004;
    localparam logic [31:0] A_BAUD   = 32'h008;
    localparam logic [31:0] A_CTRL   = 32'h00C;
`ifdef UART_TX_IRQ_EN
    localparam logic [31:0] CTRL_HI_RD = 32'h2;
`else
    localparam logic [31:0] CTRL_HI_RD = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] data_store = '0;
    logic        data_read = 1'b0;
    logic        data_enable = 1'b0;
    logic        mmio_sel = 1'b0;
    logic [31:0] data_fetch;
    logic        tx;
    logic        irq;

    mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .rst_n(rst_n), .data_address(data_address),
        .data_store(data_store), .data_read(data_read),
        .data_enable(data_enable), .mmio_sel(mmio_sel),
        .data_fetch(data_fetch), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Waveform capture, one sample per clock, taken on the falling edge.
    bit tx_q[$];
    bit irq_q[$];
    bit rec_on = 1'b0;
    always @(negedge clk) begin
        if (rec_on) begin
            tx_q.push_back(tx);
            irq_q.push_back(irq);
        end
    end

    // Reference model: the expected frames as a list of bytes, each with its bit length.
    logic [7:0] exp_bytes[$];
    int         exp_divs[$];

    typedef struct {
        bit          wr;
        bit          sel;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_access(input bit sel, input bit rd, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] v);
        mmio_sel = sel; data_enable = 1'b1; data_read = rd;
        data_address = a; data_store = d;
        @(posedge clk); #1;
        v = data_fetch;
        mmio_sel = 1'b0; data_enable = 1'b0; data_read = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        bus_access(1'b1, 1'b0, a, d, v);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        bus_access(1'b1, 1'b1, a, 32'd0, v);
    endtask

    // Poll STATUS until the FIFO is empty and the transmitter is idle.
    task automatic wait_idle(input string tag, input int budget);
        logic [31:0] v;
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            bus_read(A_STATUS, v);
            if (v[2] == 1'b0 && v[1] == 1'b1) done = 1'b1;
        end
        chk({tag, "_idle_reached"}, {31'd0, done}, 32'd1);
    endtask

    function automatic int find_zero(input int from);
        for (int i = from; i < tx_q.size(); i++)
            if (tx_q[i] == 1'b0) return i;
        return -1;
    endfunction

    // Compare the captured tx trace with the expected frame list. Consecutive
    // frames must be separated by exactly one idle cycle.
    task automatic check_frames(input string tag);
        int s, d, bad, nxt;
        logic [7:0] b;
        bit e;
        s = find_zero(0);
        for (int k = 0; k < exp_bytes.size(); k++) begin
            d = exp_divs[k];
            b = exp_bytes[k];
            if (s < 0 || s + 10*d > tx_q.size()) begin
                chk($sformatf("%s_frame%0d_present", tag, k), 32'd0, 32'd1);
                return;
            end
            bad = 0;
            for (int i = 0; i < 10; i++) begin
                e = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
                for (int j = 0; j < d; j++)
                    if (tx_q[s + i*d + j] !== e) bad++;
            end
            $display("%s frame %0d: byte 0x%02h div %0d start %0d bad_samples %0d",
                     tag, k, b, d, s, bad);
            chk($sformatf("%s_frame%0d_bits", tag, k), 32'(bad), 32'd0);
            nxt = find_zero(s + 10*d);
            if (k + 1 < exp_bytes.size())
                chk($sformatf("%s_gap%0d", tag, k), 32'(nxt - s), 32'(10*d + 1));
            s = nxt;
        end
        chk({tag, "_no_extra_start"}, 32'(s), 32'hFFFF_FFFF);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp;
        logic [7:0]  b;
        logic [7:0]  mq[$];
        int n, bv, d, busy_cnt, bad, s1, s2, e;
        bit ovf;

        // ---------------- reset state ----------------
        tick(3);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_fetch", data_fetch, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // ---------------- register table ----------------
        tbl[0]  = '{1'b0, 1'b1, 32'h008, 32'h0, 32'h0000_01B2};
        tbl[1]  = '{1'b0, 1'b1, 32'h004, 32'h0, 32'h0000_0002};
        tbl[2]  = '{1'b0, 1'b1, 32'h00C, 32'h0, 32'h0000_0000};
        tbl[3]  = '{1'b0, 1'b1, 32'h000, 32'h0, 32'h0000_0000};
        tbl[4]  = '{1'b0, 1'b1, 32'h010, 32'h0, 32'h0000_0000};
        tbl[5]  = '{1'b1, 1'b1, 32'h008, 32'hABCD_1234, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 32'h008, 32'h0, 32'h0000_1234};
        tbl[7]  = '{1'b1, 1'b0, 32'h008, 32'h0000_0055, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'h008, 32'h0, 32'h0000_1234};
        tbl[9]  = '{1'b1, 1'b1, 32'h3FC, 32'h0000_FFFF, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 32'h3FC, 32'h0, 32'h0000_0000};
        tbl[11] = '{1'b0, 1'b1, 32'hFFFF_F408, 32'h0, 32'h0000_1234};
        tbl[12] = '{1'b1, 1'b1, 32'h00C, 32'hFFFF_FFFE, 32'h0};
        tbl[13] = '{1'b0, 1'b1, 32'h00C, 32'h0, CTRL_HI_RD};
        tbl[14] = '{1'b1, 1'b1, 32'h004, 32'hFFFF_FFFF, 32'h0};
        tbl[15] = '{1'b0, 1'b1, 32'h004, 32'h0, 32'h0000_0002};
        for (int i = 0; i < 16; i++) begin
            bus_access(tbl[i].sel, ~tbl[i].wr, tbl[i].addr, tbl[i].data, v);
            if (tbl[i].wr) begin
                $display("vec %0d: write sel=%0d addr 0x%08h data 0x%08h", i, tbl[i].sel,
                         tbl[i].addr, tbl[i].data);
            end else begin
                $display("vec %0d: read addr 0x%08h -> 0x%08h", i, tbl[i].addr, v);
                chk($sformatf("tbl%0d_read", i), v, tbl[i].exp);
            end
        end
        bus_write(A_CTRL, 32'h0);

        // ---------------- single byte 0xA5 at 4 cycles per bit ----------------
        bus_write(A_BAUD, 32'd4);
        bus_write(A_CTRL, 32'd1);
        tx_q.delete(); irq_q.delete(); rec_on = 1'b1;
        bus_write(A_TXDATA, 32'hA5);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            bus_read(A_STATUS, v);
            busy_cnt += int'(v[2]);
        end
        chk("a5_busy_cycles", 32'(busy_cnt), 32'd40);
        chk("a5_final_status", v, 32'h0000_0002);
        tick(4); rec_on = 1'b0;
        exp_bytes = '{8'hA5}; exp_divs = '{4};
        check_frames("a5");
`ifndef UART_TX_IRQ_EN
        bad = 0;
        foreach (irq_q[i]) if (irq_q[i]) bad++;
        chk("irq_tied_low", 32'(bad), 32'd0);
`endif

        // ---------------- overflow, W1C, then drain ----------------
        bus_write(A_CTRL, 32'd0);
        for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 32'h10 + 32'(i));
        bus_read(A_STATUS, v);
        chk("ovf_status", v, 32'h0000_0809);
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, v);
        chk("ovf_w1c_status", v, 32'h0000_0801);
        bus_write(A_BAUD, 32'd1);
        tx_q.delete(); irq_q.delete(); rec_on = 1'b1;
        bus_write(A_CTRL, 32'd1);
        wait_idle("drain", 400);
        tick(5); rec_on = 1'b0;
        exp_bytes.delete(); exp_divs.delete();
        for (int i = 0; i < 8; i++) begin
            exp_bytes.push_back(8'h10 + 8'(i));
            exp_divs.push_back(1);
        end
        check_frames("drain");

        // ---------------- BAUD_DIV 0, then a mid-frame change to 8 ----------------
        bus_write(A_BAUD, 32'd0);
        tx_q.delete(); irq_q.delete(); rec_on = 1'b1;
        bus_write(A_TXDATA, 32'hFF);
        tick(1);
        bus_write(A_BAUD, 32'd8);
        bus_write(A_TXDATA, 32'h3C);
        wait_idle("div0", 400);
        tick(20); rec_on = 1'b0;
        exp_bytes = '{8'hFF, 8'h3C}; exp_divs = '{1, 8};
        check_frames("div0");

        // ---------------- randomized bursts vs reference model ----------------
        for (int r = 0; r < 6; r++) begin
            bus_write(A_CTRL, 32'd0);
            n = $urandom_range(1, 11);
            ovf = 1'b0;
            mq.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                bus_write(A_TXDATA, {24'd0, b});
                if (mq.size() < DEPTH) mq.push_back(b);
                else ovf = 1'b1;
            end
            bus_read(A_STATUS, v);
            exp = {16'd0, 8'(mq.size()), 4'd0, ovf, 1'b0,
                   mq.size() == 0, mq.size() == DEPTH};
            chk($sformatf("rnd%0d_status", r), v, exp);
            bv = $urandom_range(0, 5);
            d  = (bv == 0) ? 1 : bv;
            bus_write(A_BAUD, 32'(bv));
            tx_q.delete(); irq_q.delete(); rec_on = 1'b1;
            bus_write(A_CTRL, 32'd1);
            wait_idle($sformatf("rnd%0d", r), 1500);
            tick(2*d + 4); rec_on = 1'b0;
            exp_bytes = mq;
            exp_divs.delete();
            for (int i = 0; i < mq.size(); i++) exp_divs.push_back(d);
            check_frames($sformatf("rnd%0d", r));
            if (ovf) begin
                bus_write(A_STATUS, 32'h8);
                bus_read(A_STATUS, v);
                chk($sformatf("rnd%0d_ovf_clear", r), v, 32'h0000_0002);
            end
        end

`ifdef UART_TX_IRQ_EN
        // ---------------- interrupt after the last stop bit ----------------
        bus_write(A_BAUD, 32'd2);
        bus_write(A_CTRL, 32'd3);
        tx_q.delete(); irq_q.delete(); rec_on = 1'b1;
        bus_write(A_TXDATA, 32'h11);
        bus_write(A_TXDATA, 32'h22);
        wait_idle("irq", 400);
        tick(4); rec_on = 1'b0;
        s1 = find_zero(0);
        s2 = (s1 < 0) ? -1 : find_zero(s1 + 20);
        e  = s2 + 20;
        bad = 0;
        if (s1 >= 0 && s2 >= 0 && e + 1 < irq_q.size()) begin
            for (int i = s1; i <= e; i++) if (irq_q[i]) bad++;
            chk("irq_low_during_tx", 32'(bad), 32'd0);
            chk("irq_rise_after_stop", {31'd0, irq_q[e+1]}, 32'd1);
        end else begin
            chk("irq_frames_found", 32'd0, 32'd1);
        end
        bus_write(A_TXDATA, 32'h33);
        tick(1);
        chk("irq_drop_on_push", {31'd0, irq}, 32'd0);
        wait_idle("irq2", 400);
        bus_write(A_CTRL, 32'd1);
`endif

        // ---------------- reset during DATA bit 3 ----------------
        bus_write(A_BAUD, 32'd4);
        bus_write(A_CTRL, 32'd1);
        bus_write(A_TXDATA, 32'h00);
        bus_write(A_TXDATA, 32'h55);
        bad = 1;
        for (int i = 0; i < 50 && bad != 0; i++) begin
            if (tx == 1'b0) bad = 0;
            else tick(1);
        end
        chk("rstmid_start_seen", 32'(bad), 32'd0);
        tick(17);
        chk("rstmid_bit3_low", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_tx_high", {31'd0, tx}, 32'd1);
        chk("rstmid_fetch", data_fetch, 32'd0);
        chk("rstmid_irq", {31'd0, irq}, 32'd0);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        bus_read(A_STATUS, v);
        chk("rstmid_status", v, 32'h0000_0002);
        bus_read(A_BAUD, v);
        chk("rstmid_baud", v, 32'h0000_01B2);
        bus_read(A_CTRL, v);
        chk("rstmid_ctrl", v, 32'h0000_0000);
        bus_write(A_BAUD, 32'd2);
        tx_q.delete(); irq_q.delete(); rec_on = 1'b1;
        bus_write(A_CTRL, 32'd1);
        tick(60); rec_on = 1'b0;
        exp_bytes.delete(); exp_divs.delete();
        check_frames("rstmid");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped 8N1 UART transmitter occupying one 1 KiB MMIO slot.
- Sits directly downstream of the MMIO address decoder. Its mmio_sel input is driven by one decoder mmio_vector[i] bit (i = 1..7).
- Software writes bytes into a TX FIFO. A bit-timing state machine serialises them onto the tx pin.
- Read data is registered so the SoC-top mux samples it in the cycle after the access, the same timing as the flopped cache-access select.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 16'd434, reset value of BAUD_DIV (clk cycles per bit; 50 MHz / 115200).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- data_address  input  32  core data address; only [9:0] is decoded inside the slot
- data_store  input  32  core store data
- data_read  input  1  1 = load, 0 = store; qualified by data_enable
- data_enable  input  1  data access valid
- mmio_sel  input  1  slot select from the decoder; already includes data_enable and the MMIO-range check
- data_fetch  output  32  registered read data
- tx  output  1  serial output, idle high
- irq  output  1  TX-done interrupt (see Optional Feature)

Behaviour:
- Access decode:
  - wr = mmio_sel & data_enable & ~data_read.
  - rd = mmio_sel & data_enable & data_read.
  - Offset = data_address[9:0]. Offsets not in the register map read 0 and ignore writes.
- Register map:
  - 0x000 TXDATA (W): push data_store[7:0] into the FIFO. Reads return 0.
  - 0x004 STATUS (R/W1C):
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - [15:8] FIFO count, zero-extended.
    - Writing 1 to bit3 clears overflow. All other bits are read-only.
  - 0x008 BAUD_DIV (RW): [15:0]. A value of 0 is treated as 1. Upper bits read 0.
  - 0x00C CTRL (RW): bit0 tx_en, bit1 irq_en. Reset value is 0.
- Read latency: 1 cycle.
  - data_fetch <= register value when rd; otherwise data_fetch <= 0.
  - STATUS reads reflect state before any same-cycle push or pop.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers.
  - Push when full: data dropped, overflow set, pointers unchanged.
  - A simultaneous push and pop while full is accepted: count stays FIFO_DEPTH.
  - Pop occurs only when the FSM leaves IDLE.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: tx = 1. If tx_en & ~empty: pop a byte into the shift register, latch the divider (div_lat = max(BAUD_DIV, 1)), go to START.
  - START: tx = 0 for div_lat cycles, then go to DATA with bit_cnt = 0.
  - DATA: tx = shift[0] (LSB first), div_lat cycles per bit. After bit 7, go to STOP.
  - STOP: tx = 1 for div_lat cycles, then go to IDLE. Back-to-back bytes produce no extra idle cycle beyond the one IDLE cycle used to pop.
- Bit timing:
  - The cycle counter runs 0..div_lat-1 and wraps at each bit boundary.
  - Frame length = 10*div_lat cycles, plus 1 IDLE cycle per byte.
- Mid-operation changes:
  - BAUD_DIV written mid-frame: no effect until the next frame.
  - tx_en cleared mid-frame: current frame completes; the FIFO is retained.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE, tx = 1, FIFO empty, overflow = 0.
  - BAUD_DIV = DEFAULT_DIV, CTRL = 0, data_fetch = 0, irq = 0.

Optional Feature:
- Macro: UART_TX_IRQ_EN.
- Defined: irq is registered, and irq <= irq_en & empty & (state == IDLE) & ~(pop this cycle). It rises 1 cycle after the last stop bit ends and is level-held until a push or until irq_en is cleared.
- Undefined: irq is tied to 0, CTRL bit1 is not stored and reads 0, and no interrupt logic is synthesised.

Test Plan:
- Reset, then read BAUD_DIV, STATUS and CTRL -> data_fetch one cycle later is 0x000001B2, then 0x00000002 (empty), then 0x00000000; tx = 1 throughout.
- BAUD_DIV = 4, CTRL = 1, write TXDATA 0xA5 -> tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; busy is 1 for 40 cycles; final STATUS = 0x00000002.
- CTRL = 0, push 9 bytes with FIFO_DEPTH = 8 -> STATUS = 0x00000809 (count 8, overflow, full). W1C 0x8 to STATUS -> 0x00000801.
- BAUD_DIV = 0, send 0xFF -> each bit lasts 1 cycle, frame is 10 cycles; mid-frame BAUD_DIV = 8 write does not change the current frame, and the next byte uses 8-cycle bits.
- Assert rst_n low during DATA bit 3 -> tx = 1 immediately; after release, STATUS = 0x00000002 and no residual bits are transmitted.
- With UART_TX_IRQ_EN defined, CTRL = 3, send 2 bytes -> irq stays 0 between bytes and rises 1 cycle after the second stop bit; a TXDATA write drops irq the next cycle.
